// File: rtl/tero_eval_ctrl.sv
// TERO PUF evaluation sequencer: per loop clear counter, enable loop for a window, settle, capture; pairwise compare builds the response.
// Latency: NUM_LOOPS*(WINDOW_CYCLES+SETTLE_CYCLES+2) cycles from accepted start to resp_valid; all outputs registered.
// No backpressure: start is ignored while busy; abort cancels a run; optional tie_mask output under macro TERO_TIE_MASK_EN.
module tero_eval_ctrl #(
    parameter int NUM_LOOPS      = 32,
    parameter int CHALLENGE_BITS = 8,
    parameter int CNT_WIDTH      = 16,
    parameter int WINDOW_CYCLES  = 1024,
    parameter int SETTLE_CYCLES  = 2,
    localparam int LOOP_BITS     = $clog2(NUM_LOOPS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic [CHALLENGE_BITS-1:0] challenge_in,
    input  logic [CNT_WIDTH-1:0]      cnt_value,
    output logic [LOOP_BITS-1:0]      loop_sel,
    output logic                      tero_en,
    output logic                      cnt_clear,
    output logic                      busy,
    output logic                      resp_valid,
    output logic [NUM_LOOPS/2-1:0]    response
`ifdef TERO_TIE_MASK_EN
    ,
    output logic [NUM_LOOPS/2-1:0]    tie_mask
`endif
);

    localparam int PAIRS   = NUM_LOOPS / 2;
    localparam int SEQ_W   = LOOP_BITS + 1;
    localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW_CYCLES - 1);
    localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [SEQ_W-1:0] LAST_IDX = SEQ_W'(NUM_LOOPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LOOP_BITS-1:0]   chal_q, chal_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [SEQ_W-1:0]       seq_inc;
    logic [TMR_W-1:0]       timer_q, timer_d;
    logic [CNT_WIDTH-1:0]   cnt_a_q, cnt_a_d;
    logic [LOOP_BITS-1:0]   loop_sel_q, loop_sel_d;
    logic                   tero_en_q, tero_en_d;
    logic                   cnt_clear_q, cnt_clear_d;
    logic                   busy_q, busy_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [PAIRS-1:0]       response_q, response_d;
`ifdef TERO_TIE_MASK_EN
    logic [PAIRS-1:0]       tie_q, tie_d;
`endif

    // Only the low LOOP_BITS of the challenge steer the loop order.
    logic unused_chal;
    assign unused_chal = ^challenge_in;

    // Next-state and next-output computation for the whole sequencer.
    always_comb begin
        state_d      = state_q;
        chal_d       = chal_q;
        seq_d        = seq_q;
        timer_d      = timer_q;
        cnt_a_d      = cnt_a_q;
        loop_sel_d   = loop_sel_q;
        tero_en_d    = 1'b0;
        cnt_clear_d  = 1'b0;
        busy_d       = busy_q;
        resp_valid_d = resp_valid_q;
        response_d   = response_q;
`ifdef TERO_TIE_MASK_EN
        tie_d        = tie_q;
`endif
        seq_inc      = seq_q + SEQ_W'(1);

        unique case (state_q)
            S_IDLE, S_DONE: begin
                // abort in the same cycle drops the start
                if (start && !abort) begin
                    chal_d       = challenge_in[LOOP_BITS-1:0];
                    seq_d        = '0;
                    response_d   = '0;
`ifdef TERO_TIE_MASK_EN
                    tie_d        = '0;
`endif
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b1;
                    cnt_clear_d  = 1'b1;
                    loop_sel_d   = challenge_in[LOOP_BITS-1:0];
                    state_d      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                tero_en_d = 1'b1;
                timer_d   = WIN_LOAD;
                state_d   = S_MEASURE;
            end
            S_MEASURE: begin
                if (timer_q == '0) begin
                    if (SETTLE_CYCLES > 0) begin
                        timer_d = SET_LOAD;
                        state_d = S_SETTLE;
                    end else begin
                        state_d = S_CAPTURE;
                    end
                end else begin
                    tero_en_d = 1'b1;
                    timer_d   = timer_q - TMR_W'(1);
                end
            end
            S_SETTLE: begin
                if (timer_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_CAPTURE: begin
                if (!seq_q[0]) begin
                    cnt_a_d = cnt_value;
                end else begin
                    for (int k = 0; k < PAIRS; k++) begin
                        if (seq_q[SEQ_W-1:1] == LOOP_BITS'(k)) begin
                            response_d[k] = (cnt_a_q > cnt_value);
`ifdef TERO_TIE_MASK_EN
                            tie_d[k]      = (cnt_a_q == cnt_value);
`endif
                        end
                    end
                end
                if (seq_q == LAST_IDX) begin
                    busy_d       = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    seq_d       = seq_inc;
                    cnt_clear_d = 1'b1;
                    loop_sel_d  = seq_inc[LOOP_BITS-1:0] ^ chal_q;
                    state_d     = S_CLEAR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort only matters during a run; it returns everything to idle.
        if (abort && busy_q) begin
            state_d      = S_IDLE;
            tero_en_d    = 1'b0;
            cnt_clear_d  = 1'b0;
            busy_d       = 1'b0;
            resp_valid_d = 1'b0;
            response_d   = '0;
            loop_sel_d   = '0;
`ifdef TERO_TIE_MASK_EN
            tie_d        = '0;
`endif
        end
    end

    // State and registered outputs, synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            chal_q       <= '0;
            seq_q        <= '0;
            timer_q      <= '0;
            cnt_a_q      <= '0;
            loop_sel_q   <= '0;
            tero_en_q    <= 1'b0;
            cnt_clear_q  <= 1'b0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            response_q   <= '0;
`ifdef TERO_TIE_MASK_EN
            tie_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            chal_q       <= chal_d;
            seq_q        <= seq_d;
            timer_q      <= timer_d;
            cnt_a_q      <= cnt_a_d;
            loop_sel_q   <= loop_sel_d;
            tero_en_q    <= tero_en_d;
            cnt_clear_q  <= cnt_clear_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            response_q   <= response_d;
`ifdef TERO_TIE_MASK_EN
            tie_q        <= tie_d;
`endif
        end
    end

    assign loop_sel   = loop_sel_q;
    assign tero_en    = tero_en_q;
    assign cnt_clear  = cnt_clear_q;
    assign busy       = busy_q;
    assign resp_valid = resp_valid_q;
    assign response   = response_q;
`ifdef TERO_TIE_MASK_EN
    assign tie_mask   = tie_q;
`endif

endmodule

// File: doc/tero_eval_ctrl.md
Name: tero_eval_ctrl

Overview:
- Sequencer for the TERO PUF evaluation datapath: walks every TERO loop in a challenge-dependent order.
- Per loop: clears the external oscillation counter, enables the selected loop for a fixed window, then captures the count.
- Compares the two counts of each loop pair to build the response word.
- Sits between the PUF top-level request interface and the TERO loop mux / oscillation counter.

Parameters:
- NUM_LOOPS, 32: total TERO loops; power of two, >= 2. LOOP_BITS = $clog2(NUM_LOOPS).
- CHALLENGE_BITS, 8: challenge width; must be >= LOOP_BITS.
- CNT_WIDTH, 16: oscillation counter width.
- WINDOW_CYCLES, 1024: cycles tero_en is held high per loop; >= 1.
- SETTLE_CYCLES, 2: idle cycles after tero_en drops, before capture (covers counter synchroniser); >= 0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request evaluation; accepted only in IDLE or DONE.
- abort  in  1  cancel run in progress.
- challenge_in  in  CHALLENGE_BITS  challenge; sampled on accepted start.
- cnt_value  in  CNT_WIDTH  count from the external oscillation counter.
- loop_sel  out  LOOP_BITS  TERO loop index driven to the loop mux.
- tero_en  out  1  enable for the selected loop.
- cnt_clear  out  1  clear pulse to the oscillation counter.
- busy  out  1  high while a run is in progress.
- resp_valid  out  1  response valid.
- response  out  NUM_LOOPS/2  one bit per loop pair.

Behaviour:
- Reset values: loop_sel=0, tero_en=0, cnt_clear=0, busy=0, resp_valid=0, response=0, state=IDLE.
- States: IDLE, CLEAR, MEASURE, SETTLE, CAPTURE, DONE.
- Run sequence:
  - Start accepted in cycle 0: latch chal_q; seq_idx=0; response cleared; resp_valid=0 from cycle 1.
  - CLEAR (1 cycle): cnt_clear=1.
  - MEASURE (WINDOW_CYCLES cycles): tero_en=1.
  - SETTLE (SETTLE_CYCLES cycles; skipped if 0): tero_en=0.
  - CAPTURE (1 cycle): sample cnt_value.
- Cost per loop: L = WINDOW_CYCLES + SETTLE_CYCLES + 2 cycles.
- Loop order: loop_sel = seq_idx XOR chal_q[LOOP_BITS-1:0]. It is valid from CLEAR through CAPTURE and held constant for the whole loop slot.
- Capture and compare:
  - Even seq_idx: CAPTURE stores cnt_a.
  - Odd seq_idx: CAPTURE sets response[seq_idx>>1] = (cnt_a > cnt_value), unsigned compare.
  - Equal counts give 0.
- Advance: after CAPTURE, seq_idx increments and the next CLEAR follows. After the CAPTURE with seq_idx = NUM_LOOPS-1, go to DONE.
- DONE: resp_valid=1 from cycle NUM_LOOPS*L+1 onward; response held stable; busy=0.
- busy=1 in CLEAR, MEASURE, SETTLE and CAPTURE.
- start while busy: ignored; challenge is not re-latched.
- start in DONE: accepted; behaves as a start from IDLE.
- abort while busy: next cycle state=IDLE, tero_en=0, cnt_clear=0, busy=0, resp_valid=0, response=0.
- abort in IDLE or DONE: no effect.
- abort and start in the same cycle: abort wins; start is dropped.
- reset mid-run: same as power-on reset, takes effect on the next edge.
- seq_idx is LOOP_BITS+1 wide, so wrap-around is impossible.

Optional Feature:
- Macro: TERO_TIE_MASK_EN.
- Defined:
  - Extra output port tie_mask [NUM_LOOPS/2-1:0].
  - Bit k is set when both counts of pair k are equal.
  - Updated in the same cycle as response[k]; cleared on start, abort and reset.
  - Valid when resp_valid=1.
- Undefined: port absent; equal counts silently give response bit 0.

Test Plan:
1. Reset check: assert reset mid-MEASURE -> next cycle tero_en=0, busy=0, resp_valid=0, response=0, loop_sel=0.
2. Identity order: NUM_LOOPS=4, WINDOW=8, SETTLE=2, challenge 8'h00, model counts loop0..3 = 100,50,30,70.
   - loop_sel sequence 0,1,2,3, each for 12 cycles.
   - cnt_clear is a 1-cycle pulse per loop.
   - resp_valid rises at cycle 49; response=2'b01.
3. Permuted order: same setup, challenge 8'h01 -> loop_sel order 1,0,3,2; response=2'b10.
4. Protocol: start pulse during MEASURE -> ignored, still completes at cycle 49. Then abort in MEASURE of loop 2 -> IDLE next cycle, tero_en=0, resp_valid stays 0.
5. Ties and extremes:
   - Counts 16'hFFFF vs 16'hFFFE -> bit=1.
   - Counts 7 vs 7 -> bit=0; tie_mask bit=1 with TERO_TIE_MASK_EN.
   - Test reruns with and without the macro.
6. Back-to-back: start in DONE with new challenge -> resp_valid drops in cycle 1; new response after 49 cycles; simultaneous abort+start in DONE -> stays DONE, response unchanged.
